// File: rtl/hop_chain_if.sv
// Bundle between the hop-chain checker and its environment: chain stimulus/tail
// inputs in, per-lane results and the FSM state out.
`timescale 1ns/1ps
interface hop_chain_if #(
  parameter int LANES = 4,
  parameter int ERR_W = 16
);
  logic             enable;
  logic [LANES-1:0] start_tap;
  logic [LANES-1:0] chain_out;
  logic [LANES-1:0] lane_mask;
  logic             clear_err;
  logic [1:0]       state;
  logic             check_valid;
  logic [LANES-1:0] lane_mismatch;
  logic [ERR_W-1:0] err_count;
  logic [LANES-1:0] fail_sticky;
  logic [LANES-1:0] first_err;

  // check_valid is a pure valid qualifier for lane_mismatch: one result per
  // cycle while it is high, no ready/backpressure; consumers must sample it.
  modport master (
    output enable, start_tap, chain_out, lane_mask, clear_err,
    input  state, check_valid, lane_mismatch, err_count, fail_sticky, first_err
  );
  modport slave (
    input  enable, start_tap, chain_out, lane_mask, clear_err,
    output state, check_valid, lane_mismatch, err_count, fail_sticky, first_err
  );
endinterface

// File: rtl/hop_chain_checker.sv
// Compares multi-lane register-chain tails against a LATENCY-delayed copy of
// the head stimulus; reports per-lane mismatches, a saturating count and sticky flags.
`timescale 1ns/1ps
module hop_chain_checker #(
  parameter int LANES   = 4,
  parameter int LATENCY = 5,
  parameter int ERR_W   = 16
) (
  input  logic      clock0,
  input  logic      rst1,
  hop_chain_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int PCW = $clog2(LANES + 1);
  localparam int SW  = ERR_W + PCW;
  localparam logic [SW-1:0] CNT_MAX = {{PCW{1'b0}}, {ERR_W{1'b1}}};

  state_t                        st_q;
  logic [LATENCY-1:0][LANES-1:0] exp_q;
  logic [LATENCY-1:0]            vld_q;
  logic                          cv_q;
  logic [LANES-1:0]              lm_q;
  logic [ERR_W-1:0]              cnt_q;
  logic [LANES-1:0]              sticky_q;
  logic [LANES-1:0]              first_q;

  logic             qual;
  logic [LANES-1:0] raw;
  logic [PCW-1:0]   pc;
  logic [ERR_W-1:0] cnt_base;
  logic [SW-1:0]    cnt_sum;
  logic [ERR_W-1:0] cnt_next;
  logic [LANES-1:0] sticky_base;
  logic [LANES-1:0] first_base;

  assign qual = vld_q[LATENCY-1] && (st_q == CHECK);
  assign raw  = (bus.chain_out ^ exp_q[LATENCY-1]) & ~bus.lane_mask;

  // Counters consume the registered mismatch vector, so they trail it by one
  // cycle; a clear rebases them to zero before that cycle's increment.
  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) begin
      pc = pc + PCW'(lm_q[i]);
    end
    cnt_base    = bus.clear_err ? '0 : cnt_q;
    sticky_base = bus.clear_err ? '0 : sticky_q;
    first_base  = bus.clear_err ? '0 : first_q;
    cnt_sum     = {{PCW{1'b0}}, cnt_base} + {{ERR_W{1'b0}}, pc};
    cnt_next    = (cnt_sum > CNT_MAX) ? {ERR_W{1'b1}} : cnt_sum[ERR_W-1:0];
  end

  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      st_q     <= IDLE;
      exp_q    <= '0;
      vld_q    <= '0;
      cv_q     <= 1'b0;
      lm_q     <= '0;
      cnt_q    <= '0;
      sticky_q <= '0;
      first_q  <= '0;
    end else begin
      exp_q[0] <= bus.start_tap;
      vld_q[0] <= bus.enable;
      // While idle the valid history is wiped so a re-enable always refills fully.
      for (int k = 1; k < LATENCY; k++) begin
        exp_q[k] <= exp_q[k-1];
        vld_q[k] <= (st_q == IDLE) ? 1'b0 : vld_q[k-1];
      end

      case (st_q)
        IDLE: begin
          if (bus.enable) st_q <= FILL;
        end
        FILL: begin
          if (!bus.enable)            st_q <= IDLE;
          else if (vld_q[LATENCY-1])  st_q <= CHECK;
        end
        CHECK: begin
          if (!bus.enable) st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase

      cv_q     <= qual;
      lm_q     <= qual ? raw : '0;
      cnt_q    <= cnt_next;
      sticky_q <= sticky_base | lm_q;
      first_q  <= (first_base == '0) ? lm_q : first_base;
    end
  end

  assign bus.state         = st_q;
  assign bus.check_valid   = cv_q;
  assign bus.lane_mismatch = lm_q;
  assign bus.err_count     = cnt_q;
  assign bus.fail_sticky   = sticky_q;
  assign bus.first_err     = first_q;
endmodule

// File: tb/tb_hop_chain_checker.sv
// Bench for hop_chain_checker: random chain stimulus with injected tail faults,
// checked cycle by cycle against a reference model through an expected queue.
`timescale 1ns/1ps
module tb_hop_chain_checker;
  localparam int LANES   = 4;
  localparam int LATENCY = 5;
  localparam int ERR_W   = 4;
  localparam int W       = 3 + 3 * LANES + ERR_W;

  logic clock0 = 1'b0;
  logic rst1;

  hop_chain_if #(.LANES(LANES), .ERR_W(ERR_W)) bus ();

  hop_chain_checker #(.LANES(LANES), .LATENCY(LATENCY), .ERR_W(ERR_W)) dut (
    .clock0 (clock0),
    .rst1   (rst1),
    .bus    (bus)
  );

  // ---------------- clock ----------------
  always #5 clock0 = ~clock0;

  // ---------------- scoreboard state ----------------
  int               n_vec = 0;
  int               n_bad = 0;
  logic [W-1:0]     exp_q[$];

  // Reference model: run = consecutive enabled edges since idle/reset.
  int               m_run;
  int               m_cnt;
  logic [LANES-1:0] m_lm, m_sticky, m_first;
  logic [LANES-1:0] ref_hist[$];
  logic [LANES-1:0] chain_hist[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_lm = '0; m_sticky = '0; m_first = '0;
    ref_hist = {};
    repeat (LATENCY) ref_hist.push_back('0);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_state"},  32'(bus.state), 0);
    cmp({tag, "_cv"},     32'(bus.check_valid), 0);
    cmp({tag, "_lm"},     32'(bus.lane_mismatch), 0);
    cmp({tag, "_cnt"},    32'(bus.err_count), 0);
    cmp({tag, "_sticky"}, 32'(bus.fail_sticky), 0);
    cmp({tag, "_first"},  32'(bus.first_err), 0);
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, predict the post-edge outputs, wait the edge.
  task automatic step(input logic en, input logic [LANES-1:0] fault,
                      input logic [LANES-1:0] mask, input logic clr);
    logic [LANES-1:0] st, co, old, bs, bf, lm_new;
    logic             cv;
    logic [1:0]       sn;
    int               base;
    #1;
    st = LANES'($urandom_range(0, (1 << LANES) - 1));
    co = chain_hist[0] ^ fault;
    void'(chain_hist.pop_front());
    chain_hist.push_back(st);
    bus.enable    = en;
    bus.start_tap = st;
    bus.chain_out = co;
    bus.lane_mask = mask;
    bus.clear_err = clr;

    cv  = (m_run >= LATENCY + 1);
    old = ref_hist.pop_front();
    ref_hist.push_back(st);
    lm_new = cv ? ((co ^ old) & ~mask) : '0;
    base  = clr ? 0 : m_cnt;
    m_cnt = base + $countones(m_lm);
    if (m_cnt > (1 << ERR_W) - 1) m_cnt = (1 << ERR_W) - 1;
    bs = clr ? '0 : m_sticky;
    m_sticky = bs | m_lm;
    bf = clr ? '0 : m_first;
    m_first = (bf == '0) ? m_lm : bf;
    m_lm  = lm_new;
    m_run = en ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
    sn = (m_run == 0) ? 2'd0 : ((m_run <= LATENCY) ? 2'd1 : 2'd2);
    exp_q.push_back({sn, cv, m_lm, ERR_W'(m_cnt), m_sticky, m_first});
    @(posedge clock0);
    @(negedge clock0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock0) begin
    logic [W-1:0] e;
    if (!rst1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("state",         32'(bus.state),         32'(e[18:17]));
      cmp("check_valid",   32'(bus.check_valid),   32'(e[16]));
      cmp("lane_mismatch", 32'(bus.lane_mismatch), 32'(e[15:12]));
      cmp("err_count",     32'(bus.err_count),     32'(e[11:8]));
      cmp("fail_sticky",   32'(bus.fail_sticky),   32'(e[7:4]));
      cmp("first_err",     32'(bus.first_err),     32'(e[3:0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst1 = 1'b1;
    bus.enable = 1'b0; bus.start_tap = '0; bus.chain_out = '0;
    bus.lane_mask = '0; bus.clear_err = 1'b0;
    chain_hist = {};
    repeat (LATENCY) chain_hist.push_back('0);
    model_reset();
    repeat (2) @(negedge clock0);
    check_zero("reset");
    rst1 = 1'b0;

    // clean run
    repeat (200) step(1'b1, '0, '0, 1'b0);
    cmp("clean_cnt",    32'(bus.err_count), 0);
    cmp("clean_sticky", 32'(bus.fail_sticky), 0);

    // single-cycle faults on lane 2 then lane 0
    step(1'b1, 4'b0100, '0, 1'b0);
    repeat (3) step(1'b1, '0, '0, 1'b0);
    cmp("inj1_cnt",    32'(bus.err_count), 1);
    cmp("inj1_sticky", 32'(bus.fail_sticky), 32'h4);
    cmp("inj1_first",  32'(bus.first_err), 32'h4);
    step(1'b1, 4'b0001, '0, 1'b0);
    repeat (3) step(1'b1, '0, '0, 1'b0);
    cmp("inj2_cnt",    32'(bus.err_count), 2);
    cmp("inj2_sticky", 32'(bus.fail_sticky), 32'h5);
    cmp("inj2_first",  32'(bus.first_err), 32'h4);

    // masking
    step(1'b1, '0, '0, 1'b1);
    repeat (2) step(1'b1, '0, '0, 1'b0);
    cmp("clr_cnt", 32'(bus.err_count), 0);
    step(1'b1, 4'b0010, 4'b0010, 1'b0);
    repeat (2) step(1'b1, '0, '0, 1'b0);
    cmp("mask_cnt", 32'(bus.err_count), 0);
    step(1'b1, 4'b0010, '0, 1'b0);
    repeat (2) step(1'b1, '0, '0, 1'b0);
    cmp("unmask_cnt",    32'(bus.err_count), 1);
    cmp("unmask_sticky", 32'(bus.fail_sticky), 32'h2);

    // saturation, then clear on a mismatch edge
    step(1'b1, '0, '0, 1'b1);
    repeat (5) step(1'b1, 4'b1111, '0, 1'b0);
    repeat (2) step(1'b1, '0, '0, 1'b0);
    cmp("sat_cnt", 32'(bus.err_count), 15);
    step(1'b1, 4'b0011, '0, 1'b0);
    step(1'b1, '0, '0, 1'b1);
    cmp("clrhit_cnt",    32'(bus.err_count), 2);
    cmp("clrhit_sticky", 32'(bus.fail_sticky), 32'h3);
    cmp("clrhit_first",  32'(bus.first_err), 32'h3);

    // randomized faults, masks, clears and enable drops
    for (int i = 0; i < 300; i++) begin
      logic             en, clr;
      logic [LANES-1:0] f, m;
      en  = ($urandom_range(0, 19) != 0);
      f   = ($urandom_range(0, 9) == 0) ? LANES'($urandom_range(1, 15)) : '0;
      m   = ($urandom_range(0, 7) == 0) ? LANES'($urandom_range(1, 15)) : '0;
      clr = ($urandom_range(0, 29) == 0);
      step(en, f, m, clr);
    end

    // asynchronous reset mid-run
    repeat (10) step(1'b1, '0, '0, 1'b0);
    #2 rst1 = 1'b1;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge clock0);
    @(negedge clock0);
    rst1 = 1'b0;
    repeat (5) step(1'b1, '0, '0, 1'b0);
    cmp("rst_fill_state", 32'(bus.state), 1);
    step(1'b1, '0, '0, 1'b0);
    cmp("rst_check_state", 32'(bus.state), 2);
    repeat (10) step(1'b1, '0, '0, 1'b0);

    // enable toggle in CHECK
    step(1'b0, '0, '0, 1'b0);
    cmp("tog_idle_state", 32'(bus.state), 0);
    repeat (5) step(1'b1, '0, '0, 1'b0);
    cmp("tog_fill_state", 32'(bus.state), 1);
    step(1'b1, '0, '0, 1'b0);
    cmp("tog_check_state", 32'(bus.state), 2);
    cmp("tog_cv_low",      32'(bus.check_valid), 0);
    step(1'b1, '0, '0, 1'b0);
    cmp("tog_cv_high",     32'(bus.check_valid), 1);
    repeat (20) step(1'b1, '0, '0, 1'b0);

    @(negedge clock0);
    cmp("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
